bf_io_bridge: RTL and testbench
===============================

# bf_io_bridge

Buffered byte-I/O bridge between the brainfuck core (`proc`) and the UART transmitter/receiver, replacing the ad-hoc stdout edge-detect and "stall while UART busy" glue in the top level. Stdout bytes are captured on the rising edge of `stdout_en` into a parametrised TX FIFO and drained to `uart_tx` through a start/ready handshake. Received bytes are buffered in an RX FIFO and served on request as stdin. The core is stalled via `cpu_en` only when the TX FIFO is full or a stdin request cannot be served.

## Interface
- `DATA_WIDTH`, 8, byte width on all data paths
- `TX_DEPTH`, 16, TX FIFO entries; power of two, ≥2
- `RX_DEPTH`, 16, RX FIFO entries; power of two, ≥2
- `LVL_W`, $clog2(max(TX_DEPTH,RX_DEPTH))+1, width of level outputs (derived)

Ports:
- `clk`  in  1  single clock (the CPU clock domain; UART modules are on the same clock)
- `reset`  in  1  asynchronous, active-high
- `stdout`  in  DATA_WIDTH  byte from core
- `stdout_en`  in  1  level; each 0→1 transition is one byte
- `stdin_req`  in  1  level; core holds high until it sees `stdin_valid`
- `stdin`  out  DATA_WIDTH  byte to core
- `stdin_valid`  out  1  one-cycle pulse, `stdin` valid
- `cpu_en`  out  1  core enable; low = stall
- `uart_tx_data`  out  DATA_WIDTH  byte to transmitter
- `uart_tx_start`  out  1  one-cycle start pulse
- `uart_tx_ready`  in  1  transmitter idle
- `uart_rx_data`  in  DATA_WIDTH  received byte
- `uart_rx_valid`  in  1  one-cycle pulse per received byte
- `flag_clr`  in  1  clears sticky overflow flags
- `tx_level`, `rx_level`  out  LVL_W  current FIFO occupancy
- `tx_overflow`, `rx_overflow`  out  1  sticky drop flags

## Operation
- Reset (async): FIFOs empty, TX FSM in IDLE, `stdout_en_d`=0, `armed`=1. Outputs: `stdin`=0, `stdin_valid`=0, `uart_tx_data`=0, `uart_tx_start`=0, levels 0, flags 0. `cpu_en` = !`stdin_req`.
- Stdout capture: push = `stdout_en` & !`stdout_en_d` (`stdout_en_d` registered). Push while TX full (after same-cycle pop) → byte dropped, `tx_overflow`←1.
- TX FSM:
  - IDLE: FIFO non-empty & `uart_tx_ready` → latch head into `uart_tx_data`, pop, go START.
  - START: `uart_tx_start`=1 for exactly this cycle → WAIT_BUSY.
  - WAIT_BUSY: `uart_tx_ready`=0 → WAIT_DONE.
  - WAIT_DONE: `uart_tx_ready`=1 → IDLE.
- RX: `uart_rx_valid` pushes `uart_rx_data`. When full, the byte is dropped and `rx_overflow`←1. A simultaneous pop frees the slot, so the push is accepted.
- Stdin: when `armed` & `stdin_req` & RX non-empty, register head into `stdin`, pulse `stdin_valid`, pop, clear `armed`. `armed` is set again when `stdin_req` is sampled low. A held request never consumes a second byte.
- `cpu_en` (combinational from registers/inputs) = !(`tx_level`==TX_DEPTH) & !(`stdin_req` & `armed`).
- Flags: `flag_clr` clears both flags. If a set and a clear happen in the same cycle, the set wins.
- FIFO pointers are LVL_W-bit binary and wrap modulo depth. Full/empty are derived from the level counters.

## Timing
- Stdout → `uart_tx_start`: a rising `stdout_en` sampled at edge N (FIFO empty, UART ready) gives a push at N, latch/pop at N+1, and `uart_tx_start` high during cycle N+1→N+2. Latency is 2 cycles.
- Back-to-back bytes: minimum 4 cycles between start pulses plus UART busy time.
- Stdin: a request with RX non-empty gives `stdin_valid` 1 cycle later. `cpu_en` is low for that cycle and returns high in the same cycle `stdin_valid` is high.
- Request with RX empty: stall until the cycle after the `uart_rx_valid` push.
- `tx_level`/`rx_level` update on the edge of the push/pop. A simultaneous push+pop leaves the level unchanged.
- Reset mid-transfer: the FSM returns to IDLE and the FIFO contents are discarded. `uart_tx_start` is forced low immediately (async).

## Test plan
- Single byte 0x41 on an idle system, UART drops ready 1 cycle after start and raises it 10 cycles later → exactly one `uart_tx_start` pulse, 2 cycles after the `stdout_en` edge, with data 0x41. Level returns to 0.
- 17 stdout edges (0x00..0x10) with UART held busy, TX_DEPTH=16 → `cpu_en` low after the 16th. The 17th is dropped and `tx_overflow`=1. Release UART → 0x00..0x0F transmitted in order.
- `stdout_en` held high for 5 cycles → only one byte pushed.
- `stdin_req` high with RX empty, then `uart_rx_valid` with 0x5A → `cpu_en` low until the push. One cycle later `stdin`=0x5A, `stdin_valid` pulses, `cpu_en` rises.
- RX FIFO holds 0x01, 0x02 and `stdin_req` is held high for 6 cycles → only 0x01 delivered. After `stdin_req` goes low and high again, 0x02 is delivered.
- Assert `reset` during WAIT_BUSY with 3 bytes queued → all outputs reach reset values immediately. No start pulse after release until a new byte is pushed.

Source files
------------

// File: rtl/bf_io_bridge.sv
// Buffered byte-I/O bridge between the brainfuck core and the UART pair:
// a TX FIFO drained through a start/ready handshake and an RX FIFO that serves stdin requests.
module bf_io_bridge #(
  parameter int DATA_WIDTH = 8,
  parameter int TX_DEPTH   = 16,
  parameter int RX_DEPTH   = 16,
  parameter int LVL_W      = $clog2((TX_DEPTH > RX_DEPTH) ? TX_DEPTH : RX_DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] stdout,
  input  logic                  stdout_en,
  input  logic                  stdin_req,
  output logic [DATA_WIDTH-1:0] stdin,
  output logic                  stdin_valid,
  output logic                  cpu_en,
  output logic [DATA_WIDTH-1:0] uart_tx_data,
  output logic                  uart_tx_start,
  input  logic                  uart_tx_ready,
  input  logic [DATA_WIDTH-1:0] uart_rx_data,
  input  logic                  uart_rx_valid,
  input  logic                  flag_clr,
  output logic [LVL_W-1:0]      tx_level,
  output logic [LVL_W-1:0]      rx_level,
  output logic                  tx_overflow,
  output logic                  rx_overflow
);

  localparam int TX_AW = $clog2(TX_DEPTH);
  localparam int RX_AW = $clog2(RX_DEPTH);
  localparam logic [LVL_W-1:0] TX_FULL_LVL = LVL_W'(TX_DEPTH);
  localparam logic [LVL_W-1:0] RX_FULL_LVL = LVL_W'(RX_DEPTH);
  localparam logic [LVL_W-1:0] TX_LAST     = LVL_W'(TX_DEPTH - 1);
  localparam logic [LVL_W-1:0] RX_LAST     = LVL_W'(RX_DEPTH - 1);
  localparam logic [LVL_W-1:0] LVL_ZERO    = {LVL_W{1'b0}};
  localparam logic [LVL_W-1:0] LVL_ONE     = {{(LVL_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_START     = 2'd1,
    S_WAIT_BUSY = 2'd2,
    S_WAIT_DONE = 2'd3
  } tx_state_t;

  function automatic logic [LVL_W-1:0] ptr_inc(input logic [LVL_W-1:0] ptr,
                                               input logic [LVL_W-1:0] last);
    logic [LVL_W-1:0] nxt;
    if (ptr == last) nxt = LVL_ZERO;
    else             nxt = ptr + LVL_ONE;
    return nxt;
  endfunction

  function automatic logic [LVL_W-1:0] lvl_next(input logic [LVL_W-1:0] lvl,
                                                input logic inc, input logic dec);
    logic [LVL_W-1:0] nxt;
    case ({inc, dec})
      2'b10:   nxt = lvl + LVL_ONE;
      2'b01:   nxt = lvl - LVL_ONE;
      default: nxt = lvl;
    endcase
    return nxt;
  endfunction

  logic [DATA_WIDTH-1:0] tx_mem [TX_DEPTH];
  logic [DATA_WIDTH-1:0] rx_mem [RX_DEPTH];

  tx_state_t             state_q, state_d;
  logic [LVL_W-1:0]      tx_wr_q, tx_rd_q, tx_lvl_q, tx_lvl_d;
  logic [LVL_W-1:0]      rx_wr_q, rx_rd_q, rx_lvl_q, rx_lvl_d;
  logic                  stdout_en_q;
  logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
  logic                  tx_start_q, tx_start_d;
  logic                  tx_ovf_q, tx_ovf_d, rx_ovf_q, rx_ovf_d;
  logic [DATA_WIDTH-1:0] stdin_q, stdin_d;
  logic                  stdin_valid_q, armed_q, armed_d;

  logic tx_full_s, tx_empty_s, tx_push_s, tx_pop_s, tx_wr_s;
  logic rx_full_s, rx_empty_s, rx_pop_s, rx_wr_s;

  // A push into a full FIFO is still accepted when the same cycle frees a slot.
  assign tx_full_s  = (tx_lvl_q == TX_FULL_LVL);
  assign tx_empty_s = (tx_lvl_q == LVL_ZERO);
  assign tx_push_s  = stdout_en & ~stdout_en_q;
  assign tx_pop_s   = (state_q == S_IDLE) & ~tx_empty_s & uart_tx_ready;
  assign tx_wr_s    = tx_push_s & (~tx_full_s | tx_pop_s);
  assign tx_lvl_d   = lvl_next(tx_lvl_q, tx_wr_s, tx_pop_s);

  assign rx_full_s  = (rx_lvl_q == RX_FULL_LVL);
  assign rx_empty_s = (rx_lvl_q == LVL_ZERO);
  assign rx_pop_s   = armed_q & stdin_req & ~rx_empty_s;
  assign rx_wr_s    = uart_rx_valid & (~rx_full_s | rx_pop_s);
  assign rx_lvl_d   = lvl_next(rx_lvl_q, rx_wr_s, rx_pop_s);

  // TX handshake FSM: latch the head byte, pulse start, then follow the UART's busy cycle.
  always_comb begin
    state_d    = state_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (tx_pop_s) begin
          tx_data_d  = tx_mem[tx_rd_q[TX_AW-1:0]];
          tx_start_d = 1'b1;
          state_d    = S_START;
        end else begin
          state_d    = S_IDLE;
        end
      end
      S_START: state_d = S_WAIT_BUSY;
      S_WAIT_BUSY: begin
        if (!uart_tx_ready) state_d = S_WAIT_DONE;
        else                state_d = S_WAIT_BUSY;
      end
      S_WAIT_DONE: begin
        if (uart_tx_ready) state_d = S_IDLE;
        else               state_d = S_WAIT_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Stdin delivery, re-arm and sticky flags; a flag set beats a simultaneous clear.
  always_comb begin
    stdin_d = stdin_q;
    armed_d = armed_q;
    if (rx_pop_s) begin
      stdin_d = rx_mem[rx_rd_q[RX_AW-1:0]];
      armed_d = 1'b0;
    end else if (!stdin_req) begin
      armed_d = 1'b1;
    end else begin
      armed_d = armed_q;
    end
    if (tx_push_s && !tx_wr_s) tx_ovf_d = 1'b1;
    else if (flag_clr)         tx_ovf_d = 1'b0;
    else                       tx_ovf_d = tx_ovf_q;
    if (uart_rx_valid && !rx_wr_s) rx_ovf_d = 1'b1;
    else if (flag_clr)             rx_ovf_d = 1'b0;
    else                           rx_ovf_d = rx_ovf_q;
  end

  // Control and pointer registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      tx_wr_q       <= LVL_ZERO;
      tx_rd_q       <= LVL_ZERO;
      tx_lvl_q      <= LVL_ZERO;
      rx_wr_q       <= LVL_ZERO;
      rx_rd_q       <= LVL_ZERO;
      rx_lvl_q      <= LVL_ZERO;
      stdout_en_q   <= 1'b0;
      tx_data_q     <= {DATA_WIDTH{1'b0}};
      tx_start_q    <= 1'b0;
      tx_ovf_q      <= 1'b0;
      rx_ovf_q      <= 1'b0;
      stdin_q       <= {DATA_WIDTH{1'b0}};
      stdin_valid_q <= 1'b0;
      armed_q       <= 1'b1;
    end else begin
      state_q       <= state_d;
      tx_wr_q       <= tx_wr_s  ? ptr_inc(tx_wr_q, TX_LAST) : tx_wr_q;
      tx_rd_q       <= tx_pop_s ? ptr_inc(tx_rd_q, TX_LAST) : tx_rd_q;
      tx_lvl_q      <= tx_lvl_d;
      rx_wr_q       <= rx_wr_s  ? ptr_inc(rx_wr_q, RX_LAST) : rx_wr_q;
      rx_rd_q       <= rx_pop_s ? ptr_inc(rx_rd_q, RX_LAST) : rx_rd_q;
      rx_lvl_q      <= rx_lvl_d;
      stdout_en_q   <= stdout_en;
      tx_data_q     <= tx_data_d;
      tx_start_q    <= tx_start_d;
      tx_ovf_q      <= tx_ovf_d;
      rx_ovf_q      <= rx_ovf_d;
      stdin_q       <= stdin_d;
      stdin_valid_q <= rx_pop_s;
      armed_q       <= armed_d;
    end
  end

  // FIFO storage needs no reset; occupancy is tracked by the level counters.
  always_ff @(posedge clk) begin
    if (tx_wr_s) tx_mem[tx_wr_q[TX_AW-1:0]] <= stdout;
    if (rx_wr_s) rx_mem[rx_wr_q[RX_AW-1:0]] <= uart_rx_data;
  end

  assign stdin         = stdin_q;
  assign stdin_valid   = stdin_valid_q;
  assign uart_tx_data  = tx_data_q;
  assign uart_tx_start = tx_start_q;
  assign tx_level      = tx_lvl_q;
  assign rx_level      = rx_lvl_q;
  assign tx_overflow   = tx_ovf_q;
  assign rx_overflow   = rx_ovf_q;
  assign cpu_en        = ~tx_full_s & ~(stdin_req & armed_q);

endmodule

// File: tb/tb_bf_io_bridge.sv
// Directed bench for bf_io_bridge with a small UART model and TX/stdin scoreboards.
module tb_bf_io_bridge;
  localparam int DW = 8;
  localparam int LW = 5;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [DW-1:0] stdout = 8'h00;
  logic          stdout_en = 1'b0;
  logic          stdin_req = 1'b0;
  logic [DW-1:0] stdin;
  logic          stdin_valid;
  logic          cpu_en;
  logic [DW-1:0] uart_tx_data;
  logic          uart_tx_start;
  logic          uart_tx_ready = 1'b1;
  logic [DW-1:0] uart_rx_data = 8'h00;
  logic          uart_rx_valid = 1'b0;
  logic          flag_clr = 1'b0;
  logic [LW-1:0] tx_level, rx_level;
  logic          tx_overflow, rx_overflow;

  bf_io_bridge #(.DATA_WIDTH(8), .TX_DEPTH(16), .RX_DEPTH(16)) dut (
    .clk(clk), .reset(reset), .stdout(stdout), .stdout_en(stdout_en),
    .stdin_req(stdin_req), .stdin(stdin), .stdin_valid(stdin_valid), .cpu_en(cpu_en),
    .uart_tx_data(uart_tx_data), .uart_tx_start(uart_tx_start), .uart_tx_ready(uart_tx_ready),
    .uart_rx_data(uart_rx_data), .uart_rx_valid(uart_rx_valid), .flag_clr(flag_clr),
    .tx_level(tx_level), .rx_level(rx_level), .tx_overflow(tx_overflow), .rx_overflow(rx_overflow)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0, fail_cnt = 0, check_cnt = 0;
  int tx_start_cnt = 0, stdin_cnt = 0, n0 = 0;
  logic [DW-1:0] sb_tx[$];
  logic [DW-1:0] sb_rx[$];
  logic [DW-1:0] mon_exp;
  logic uart_hold = 1'b0, uart_nobusy = 1'b0, busy_pend = 1'b0;
  int busy_cnt = 0;

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    check_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic stdout_byte(input logic [DW-1:0] b, input bit expect_tx);
    @(negedge clk);
    stdout = b;
    stdout_en = 1'b1;
    if (expect_tx) sb_tx.push_back(b);
    @(negedge clk);
    stdout_en = 1'b0;
  endtask

  task automatic rx_byte(input logic [DW-1:0] b);
    @(negedge clk);
    uart_rx_data = b;
    uart_rx_valid = 1'b1;
    @(negedge clk);
    uart_rx_valid = 1'b0;
  endtask

  // UART transmitter model: ready drops one cycle after start and returns 10 cycles later.
  always @(negedge clk) begin
    if (reset) begin
      busy_pend = 1'b0;
      busy_cnt = 0;
    end else begin
      if (busy_pend) begin
        if (!uart_nobusy) busy_cnt = 10;
        busy_pend = 1'b0;
      end else if (busy_cnt > 0) begin
        busy_cnt--;
      end
      if (uart_tx_start === 1'b1) busy_pend = 1'b1;
    end
    uart_tx_ready = !uart_hold && (busy_cnt == 0);
  end

  // Scoreboard monitor: every start pulse and stdin pulse must match the next queued byte.
  always @(negedge clk) begin
    if (uart_tx_start === 1'b1) begin
      tx_start_cnt++;
      if (sb_tx.size() == 0) check("tx_unexpected_start", 32'd1, 32'd0);
      else begin
        mon_exp = sb_tx.pop_front();
        check("tx_data", 32'(uart_tx_data), 32'(mon_exp));
      end
    end
    if (stdin_valid === 1'b1) begin
      stdin_cnt++;
      if (sb_rx.size() == 0) check("stdin_unexpected", 32'd1, 32'd0);
      else begin
        mon_exp = sb_rx.pop_front();
        check("stdin_data", 32'(stdin), 32'(mon_exp));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    @(negedge clk);
    check("rst_stdin", 32'(stdin), 32'd0);
    check("rst_stdin_valid", 32'(stdin_valid), 32'd0);
    check("rst_tx_data", 32'(uart_tx_data), 32'd0);
    check("rst_tx_start", 32'(uart_tx_start), 32'd0);
    check("rst_tx_level", 32'(tx_level), 32'd0);
    check("rst_rx_level", 32'(rx_level), 32'd0);
    check("rst_flags", 32'({tx_overflow, rx_overflow}), 32'd0);
    check("rst_cpu_en_noreq", 32'(cpu_en), 32'd1);
    stdin_req = 1'b1;
    #1 check("rst_cpu_en_req", 32'(cpu_en), 32'd0);
    stdin_req = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Single byte latency
    n0 = tx_start_cnt;
    @(negedge clk);
    stdout = 8'h41;
    stdout_en = 1'b1;
    sb_tx.push_back(8'h41);
    @(negedge clk);
    stdout_en = 1'b0;
    check("t1_start_n", 32'(uart_tx_start), 32'd0);
    check("t1_level_n", 32'(tx_level), 32'd1);
    @(negedge clk);
    check("t1_start_n1", 32'(uart_tx_start), 32'd1);
    check("t1_data", 32'(uart_tx_data), 32'h41);
    check("t1_level_n1", 32'(tx_level), 32'd0);
    repeat (20) @(negedge clk);
    check("t1_one_pulse", 32'(tx_start_cnt - n0), 32'd1);
    check("t1_level_end", 32'(tx_level), 32'd0);

    // stdout_en held high for 5 cycles pushes one byte
    n0 = tx_start_cnt;
    @(negedge clk);
    stdout = 8'h77;
    stdout_en = 1'b1;
    sb_tx.push_back(8'h77);
    repeat (5) @(negedge clk);
    stdout_en = 1'b0;
    repeat (20) @(negedge clk);
    check("t3_one_push", 32'(tx_start_cnt - n0), 32'd1);
    check("t3_sb_empty", 32'(sb_tx.size()), 32'd0);

    // Fill TX with UART busy, overflow on the 17th, then drain in order
    uart_hold = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 17; i++) begin
      stdout_byte(8'(i), i < 16);
      if (i == 14) check("t2_cpu_en_15", 32'(cpu_en), 32'd1);
      if (i == 15) begin
        check("t2_cpu_en_16", 32'(cpu_en), 32'd0);
        check("t2_level_16", 32'(tx_level), 32'd16);
        check("t2_ovf_16", 32'(tx_overflow), 32'd0);
      end
    end
    check("t2_ovf_17", 32'(tx_overflow), 32'd1);
    check("t2_level_17", 32'(tx_level), 32'd16);
    @(negedge clk);
    flag_clr = 1'b1;
    @(negedge clk);
    flag_clr = 1'b0;
    check("t2_ovf_clr", 32'(tx_overflow), 32'd0);
    uart_hold = 1'b0;
    for (int k = 0; k < 1000 && (sb_tx.size() != 0 || tx_level != 0); k++) @(negedge clk);
    repeat (15) @(negedge clk);
    check("t2_drained", 32'(sb_tx.size()), 32'd0);
    check("t2_level_end", 32'(tx_level), 32'd0);
    check("t2_cpu_en_end", 32'(cpu_en), 32'd1);

    // Stdin request with RX empty
    @(negedge clk);
    stdin_req = 1'b1;
    @(negedge clk);
    check("t4_stall", 32'(cpu_en), 32'd0);
    repeat (3) @(negedge clk);
    check("t4_stall_hold", 32'({cpu_en, stdin_valid}), 32'd0);
    sb_rx.push_back(8'h5A);
    rx_byte(8'h5A);
    check("t4_rx_level", 32'(rx_level), 32'd1);
    check("t4_stall_push", 32'(cpu_en), 32'd0);
    @(negedge clk);
    check("t4_valid", 32'(stdin_valid), 32'd1);
    check("t4_stdin", 32'(stdin), 32'h5A);
    check("t4_cpu_en", 32'(cpu_en), 32'd1);
    check("t4_rx_level0", 32'(rx_level), 32'd0);
    stdin_req = 1'b0;
    @(negedge clk);
    check("t4_valid_pulse", 32'(stdin_valid), 32'd0);

    // Held request consumes only one byte
    sb_rx.push_back(8'h01);
    sb_rx.push_back(8'h02);
    rx_byte(8'h01);
    rx_byte(8'h02);
    check("t5_rx_level2", 32'(rx_level), 32'd2);
    n0 = stdin_cnt;
    @(negedge clk);
    stdin_req = 1'b1;
    repeat (6) @(negedge clk);
    check("t5_one_byte", 32'(stdin_cnt - n0), 32'd1);
    check("t5_stdin1", 32'(stdin), 32'h01);
    check("t5_rx_level1", 32'(rx_level), 32'd1);
    stdin_req = 1'b0;
    @(negedge clk);
    stdin_req = 1'b1;
    repeat (3) @(negedge clk);
    check("t5_two_bytes", 32'(stdin_cnt - n0), 32'd2);
    check("t5_stdin2", 32'(stdin), 32'h02);
    stdin_req = 1'b0;
    @(negedge clk);

    // RX full boundary: simultaneous pop frees the slot, overflow, set-beats-clear
    sb_rx.push_back(8'h80);
    for (int i = 0; i < 16; i++) rx_byte(8'(8'h80 + i));
    check("rx_full_level", 32'(rx_level), 32'd16);
    check("rx_full_noovf", 32'(rx_overflow), 32'd0);
    @(negedge clk);
    stdin_req = 1'b1;
    uart_rx_data = 8'hEE;
    uart_rx_valid = 1'b1;
    @(negedge clk);
    uart_rx_valid = 1'b0;
    stdin_req = 1'b0;
    check("rx_pushpop_level", 32'(rx_level), 32'd16);
    check("rx_pushpop_noovf", 32'(rx_overflow), 32'd0);
    check("rx_pushpop_valid", 32'(stdin_valid), 32'd1);
    rx_byte(8'hEF);
    check("rx_ovf_set", 32'(rx_overflow), 32'd1);
    check("rx_ovf_level", 32'(rx_level), 32'd16);
    @(negedge clk);
    flag_clr = 1'b1;
    uart_rx_data = 8'hF0;
    uart_rx_valid = 1'b1;
    @(negedge clk);
    flag_clr = 1'b0;
    uart_rx_valid = 1'b0;
    check("rx_set_wins", 32'(rx_overflow), 32'd1);
    @(negedge clk);
    flag_clr = 1'b1;
    @(negedge clk);
    flag_clr = 1'b0;
    check("rx_ovf_clr", 32'(rx_overflow), 32'd0);
    rx_byte(8'hF1);
    check("rx_ovf_again", 32'(rx_overflow), 32'd1);

    // Reset while WAIT_BUSY with three bytes queued
    uart_nobusy = 1'b1;
    n0 = tx_start_cnt;
    for (int i = 0; i < 4; i++) stdout_byte(8'(8'hA0 + i), 1'b1);
    @(negedge clk);
    check("t6_level3", 32'(tx_level), 32'd3);
    check("t6_started", 32'(tx_start_cnt - n0), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("t6_tx_start", 32'(uart_tx_start), 32'd0);
    check("t6_tx_data", 32'(uart_tx_data), 32'd0);
    check("t6_levels", 32'({tx_level, rx_level}), 32'd0);
    check("t6_flags", 32'({tx_overflow, rx_overflow}), 32'd0);
    check("t6_stdin", 32'({stdin, stdin_valid}), 32'd0);
    check("t6_cpu_en", 32'(cpu_en), 32'd1);
    sb_tx.delete();
    sb_rx.delete();
    uart_nobusy = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    n0 = tx_start_cnt;
    repeat (30) @(negedge clk);
    check("t6_no_start", 32'(tx_start_cnt - n0), 32'd0);
    stdout_byte(8'h55, 1'b1);
    repeat (5) @(negedge clk);
    check("t6_new_start", 32'(tx_start_cnt - n0), 32'd1);
    check("t6_sb_empty", 32'(sb_tx.size()), 32'd0);
    repeat (15) @(negedge clk);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end
endmodule
